fft_butterfly: RTL and testbench
================================

# fft_butterfly

Pipelined radix-2 decimation-in-time butterfly for the 16-point FFT datapath. It sits directly downstream of the twiddle-factor ROM. Each cycle it accepts one complex pair (x, y) and the matching twiddle w, and produces z = (x + w·y)/2 and z2 = (x − w·y)/2, together with a pass-through metadata tag. The fixed /2 per stage keeps the 16-stage-bit growth bounded, and the block saturates and flags any remaining overflow.

## Interface
- WIDTH, 32: complex word width. Real part is in the upper WIDTH/2 bits, imaginary part in the lower WIDTH/2 bits. Both are signed two's complement.
- MWIDTH, 1: width of the metadata tag carried alongside the data.
- TF_SHIFT, 14: twiddle fraction bits. The value 2^TF_SHIFT (16384) represents 1.0.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_nd  in  1  new-data strobe; x, y, w and in_m are valid this cycle.
- x  in  WIDTH  complex input x.
- y  in  WIDTH  complex input y.
- w  in  WIDTH  complex twiddle (the registered ROM output).
- in_m  in  MWIDTH  metadata tag.
- out_nd  out  1  output-valid strobe.
- z  out  WIDTH  (x + w·y)/2, saturated.
- z2  out  WIDTH  (x − w·y)/2, saturated.
- out_m  out  MWIDTH  tag delayed to align with z/z2.
- error  out  1  sticky saturation flag; cleared only by rst.

## Operation
- The ROM output is registered, so the controller asserts the ROM's addr_nd one cycle before in_nd. This makes w valid in the same cycle as x, y and in_nd. The butterfly does not realign w.
- The pipeline has four register stages, each carrying a valid bit and the tag.
  - S1: register x, y, w, in_m and in_nd.
  - S2: form four signed products, each (WIDTH/2)×(WIDTH/2) → WIDTH bits: wr·yr, wi·yi, wr·yi, wi·yr.
  - S3: compute pr = wr·yr − wi·yi and pi = wr·yi + wi·yr at WIDTH+1 bits. Arithmetic-shift both right by TF_SHIFT (floor, no rounding) and keep WIDTH/2+1 bits. Delay x alongside.
  - S4: compute sums and differences at WIDTH/2+2 bits: sr = xr + pr, si = xi + pi, dr = xr − pr, di = xi − pi. Arithmetic-shift each right by 1 (floor). Saturate each component to [−2^(WIDTH/2−1), 2^(WIDTH/2−1)−1], which is [−32768, 32767] at the default width.
- Saturation is per component. If any of the four components is clipped in a valid S4 cycle, error is set to 1 and holds until rst.
- Data registers load only when the corresponding stage's valid bit is set. The valid bits themselves shift every cycle.
- Throughput is one butterfly per cycle. Gaps in in_nd are preserved exactly at the output.
- No backpressure exists. The downstream stage must accept a result whenever out_nd is 1.

## Timing
- Latency: in_nd at rising edge T gives out_nd = 1 with the matching z, z2 and out_m after edge T+4.
- out_nd is a single-cycle pulse per accepted input. z, z2 and out_m hold their last values while out_nd = 0.
- Reset values: out_nd = 0, z = 0, z2 = 0, out_m = 0, error = 0. All internal valid bits are 0.
- rst during operation: every in-flight item is discarded. No out_nd is produced for any input accepted before or during the rst cycle.
- in_nd and rst in the same cycle: rst wins and the input is dropped.
- The first input after rst falls is accepted normally, with 4-cycle latency.
- Saturation and error set: error rises in the same cycle as the out_nd carrying the clipped result.

## Test plan
- Identity twiddle.
  - Stimulus: w = (16384, 0), x = (1000, 2000), y = (200, −400), in_nd at T.
  - Required: out_nd at T+4 with z = (600, 800) and z2 = (400, 1200); error = 0.
- −j twiddle.
  - Stimulus: w = (0, −16384), x = (0, 0), y = (100, 0).
  - Required: z = (0, −50), z2 = (0, 50).
- Streaming.
  - Stimulus: 8 back-to-back in_nd, with in_m alternating 0/1 and y = (k, 0) for k = 0..7 with identity w. Then a 2-cycle gap, then 3 more inputs.
  - Required: out_nd high for 8 consecutive cycles starting at T+4, out_m alternating to match, z real = k/2 floored, then the same 2-cycle gap and 3 more outputs.
- Saturation.
  - Stimulus: w = (11585, −11585), x = (0, 32767), y = (−32768, 32767).
  - Required: z = (−1, 32767) (the imaginary part is clipped from 39553), z2 = (0, −6786), error = 1 and still 1 after 10 idle cycles.
- Reset mid-flight.
  - Stimulus: in_nd at T and T+1, rst at T+2.
  - Required: no out_nd in T+3..T+8; error = 0; an input at T+4 after rst is released yields out_nd at T+8.
- Simultaneous event.
  - Stimulus: in_nd = 1 and rst = 1 in the same cycle.
  - Required: no out_nd in the following 6 cycles.

Source files
------------

// File: rtl/fft_butterfly_if.sv
// Beat-level bundle for the radix-2 butterfly: one input pair with its twiddle and tag in,
// and one output pair with its tag out, per clock cycle. There is no backpressure.
interface fft_butterfly_if #(
   parameter int WIDTH  = 32,
   parameter int MWIDTH = 1
);
   logic              in_nd;
   logic [WIDTH-1:0]  x;
   logic [WIDTH-1:0]  y;
   logic [WIDTH-1:0]  w;
   logic [MWIDTH-1:0] in_m;

   logic              out_nd;
   logic [WIDTH-1:0]  z;
   logic [WIDTH-1:0]  z2;
   logic [MWIDTH-1:0] out_m;
   logic              error;

   modport master (
      output in_nd, x, y, w, in_m,
      input  out_nd, z, z2, out_m, error
   );

   modport slave (
      input  in_nd, x, y, w, in_m,
      output out_nd, z, z2, out_m, error
   );
endinterface

// File: rtl/fft_butterfly.sv
// Four-stage pipelined radix-2 DIT butterfly: z = (x + w*y)/2, z2 = (x - w*y)/2,
// per-component saturation with a sticky error flag, and a tag carried alongside the data.
module fft_butterfly #(
   parameter int WIDTH    = 32,
   parameter int MWIDTH   = 1,
   parameter int TF_SHIFT = 14
) (
   input  logic           clk,
   input  logic           rst,
   fft_butterfly_if.slave bf
);
   localparam int H  = WIDTH / 2;
   localparam int AW = H + 2;

   function automatic logic [H-1:0] saturate(input logic [H:0] v);
      if (v[H] == v[H-1]) begin
         return v[H-1:0];
      end
      return v[H] ? {1'b1, {(H-1){1'b0}}} : {1'b0, {(H-1){1'b1}}};
   endfunction

   // ---------------- S1: input capture ----------------
   logic              s1_valid_reg;
   logic [WIDTH-1:0]  s1_x_reg;
   logic [WIDTH-1:0]  s1_y_reg;
   logic [WIDTH-1:0]  s1_w_reg;
   logic [MWIDTH-1:0] s1_m_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
      end else begin
         s1_valid_reg <= bf.in_nd;
      end
   end

   always_ff @(posedge clk) begin
      if (bf.in_nd) begin
         s1_x_reg <= bf.x;
         s1_y_reg <= bf.y;
         s1_w_reg <= bf.w;
         s1_m_reg <= bf.in_m;
      end
   end

   // ---------------- S2: four partial products ----------------
   logic signed [WIDTH-1:0] w_ext [2];
   logic signed [WIDTH-1:0] y_ext [2];
   logic signed [WIDTH-1:0] s2_prod [4];
   logic                    s2_valid_reg;
   logic [WIDTH-1:0]        s2_x_reg;
   logic [MWIDTH-1:0]       s2_m_reg;

   // Index 0 is the real half (upper bits), index 1 the imaginary half.
   for (genvar gi = 0; gi < 2; gi++) begin : g_split
      localparam int LSB = (1 - gi) * H;
      assign w_ext[gi] = {{H{s1_w_reg[LSB+H-1]}}, s1_w_reg[LSB +: H]};
      assign y_ext[gi] = {{H{s1_y_reg[LSB+H-1]}}, s1_y_reg[LSB +: H]};
   end

   // Product order: wr*yr, wi*yi, wr*yi, wi*yr.
   for (genvar gi = 0; gi < 4; gi++) begin : g_mult
      localparam int WI = gi % 2;
      localparam int YI = (gi == 1 || gi == 2) ? 1 : 0;
      logic signed [WIDTH-1:0] prod_reg;

      always_ff @(posedge clk) begin
         if (s1_valid_reg) begin
            prod_reg <= w_ext[WI] * y_ext[YI];
         end
      end

      assign s2_prod[gi] = prod_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_reg <= 1'b0;
      end else begin
         s2_valid_reg <= s1_valid_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (s1_valid_reg) begin
         s2_x_reg <= s1_x_reg;
         s2_m_reg <= s1_m_reg;
      end
   end

   // ---------------- S3: complex product, rescaled by the twiddle fraction ----------------
   logic signed [WIDTH:0] pr_full;
   logic signed [WIDTH:0] pi_full;
   logic [H:0]            s3_pr_reg;
   logic [H:0]            s3_pi_reg;
   logic                  s3_valid_reg;
   logic [WIDTH-1:0]      s3_x_reg;
   logic [MWIDTH-1:0]     s3_m_reg;

   assign pr_full = {s2_prod[0][WIDTH-1], s2_prod[0]} - {s2_prod[1][WIDTH-1], s2_prod[1]};
   assign pi_full = {s2_prod[2][WIDTH-1], s2_prod[2]} + {s2_prod[3][WIDTH-1], s2_prod[3]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_valid_reg <= 1'b0;
      end else begin
         s3_valid_reg <= s2_valid_reg;
      end
   end

   // Slicing from TF_SHIFT upward is a flooring arithmetic shift followed by truncation.
   always_ff @(posedge clk) begin
      if (s2_valid_reg) begin
         s3_pr_reg <= pr_full[TF_SHIFT +: H+1];
         s3_pi_reg <= pi_full[TF_SHIFT +: H+1];
         s3_x_reg  <= s2_x_reg;
         s3_m_reg  <= s2_m_reg;
      end
   end

   // ---------------- S4: sum/difference, halve, saturate ----------------
   logic [H:0]   p_part   [2];
   logic [H-1:0] sum_sat  [2];
   logic [H-1:0] diff_sat [2];
   logic [3:0]   clip;
   logic [1:0]   unused_lsb;
   logic         unused_bits;

   assign p_part[0] = s3_pr_reg;
   assign p_part[1] = s3_pi_reg;

   for (genvar gi = 0; gi < 2; gi++) begin : g_addsub
      localparam int LSB = (1 - gi) * H;
      logic signed [AW-1:0] x_ext;
      logic signed [AW-1:0] p_ext;
      logic signed [AW-1:0] sum;
      logic signed [AW-1:0] diff;

      assign x_ext = {{2{s3_x_reg[LSB+H-1]}}, s3_x_reg[LSB +: H]};
      assign p_ext = {p_part[gi][H], p_part[gi]};
      assign sum   = x_ext + p_ext;
      assign diff  = x_ext - p_ext;

      // Dropping bit 0 is the floor halving; the halved value fits iff its top two bits agree.
      assign sum_sat[gi]    = saturate(sum[AW-1:1]);
      assign diff_sat[gi]   = saturate(diff[AW-1:1]);
      assign clip[2*gi]     = sum[AW-1] ^ sum[AW-2];
      assign clip[2*gi+1]   = diff[AW-1] ^ diff[AW-2];
      assign unused_lsb[gi] = sum[0] ^ diff[0];
   end

   assign unused_bits = ^{pr_full, pi_full, unused_lsb};

   // ---------------- Output registers ----------------
   logic              out_nd_reg;
   logic [WIDTH-1:0]  z_reg;
   logic [WIDTH-1:0]  z2_reg;
   logic [MWIDTH-1:0] out_m_reg;
   logic              error_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_nd_reg <= 1'b0;
         z_reg      <= '0;
         z2_reg     <= '0;
         out_m_reg  <= '0;
         error_reg  <= 1'b0;
      end else begin
         out_nd_reg <= s3_valid_reg;
         if (s3_valid_reg) begin
            z_reg     <= {sum_sat[0], sum_sat[1]};
            z2_reg    <= {diff_sat[0], diff_sat[1]};
            out_m_reg <= s3_m_reg;
            if (|clip) begin
               error_reg <= 1'b1;
            end
         end
      end
   end

   assign bf.out_nd = out_nd_reg;
   assign bf.z      = z_reg;
   assign bf.z2     = z2_reg;
   assign bf.out_m  = out_m_reg;
   assign bf.error  = error_reg;
endmodule

// File: tb/tb_fft_butterfly.sv
// Scoreboard bench for fft_butterfly: expected results are queued at drive time with their
// due cycle and compared by the output monitor; each scenario task checks its own side effects.
`timescale 1ns/1ps
module tb_fft_butterfly;
   localparam int WIDTH  = 32;
   localparam int MWIDTH = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft_butterfly_if #(.WIDTH(WIDTH), .MWIDTH(MWIDTH)) bf ();

   fft_butterfly #(.WIDTH(WIDTH), .MWIDTH(MWIDTH), .TF_SHIFT(14)) dut (
      .clk(clk),
      .rst(rst),
      .bf (bf)
   );

   typedef struct {
      logic [31:0] z;
      logic [31:0] z2;
      logic        m;
      int          due;
   } exp_t;

   exp_t sb_q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   passes = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] cplx(input int re, input int im);
      logic [15:0] r;
      logic [15:0] i;
      r = 16'(re);
      i = 16'(im);
      return {r, i};
   endfunction

   function automatic longint clamp(input longint v);
      return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
   endfunction

   // Reference: complex multiply, floor by 2^14, then floor-halved sum/difference with clipping.
   function automatic void model(input logic [31:0] xv, yv, wv,
                                 output logic [31:0] ez, ez2, output logic sat);
      longint xr, xi, yr, yi, wr, wi, pr, pim, sr, si, dr, di;
      xr = longint'($signed(xv[31:16])); xi = longint'($signed(xv[15:0]));
      yr = longint'($signed(yv[31:16])); yi = longint'($signed(yv[15:0]));
      wr = longint'($signed(wv[31:16])); wi = longint'($signed(wv[15:0]));
      pr  = (wr * yr - wi * yi) >>> 14;
      pim = (wr * yi + wi * yr) >>> 14;
      sr = (xr + pr) >>> 1;  si = (xi + pim) >>> 1;
      dr = (xr - pr) >>> 1;  di = (xi - pim) >>> 1;
      ez  = {16'(clamp(sr)), 16'(clamp(si))};
      ez2 = {16'(clamp(dr)), 16'(clamp(di))};
      sat = (clamp(sr) != sr) || (clamp(si) != si) || (clamp(dr) != dr) || (clamp(di) != di);
   endfunction

   // Called at a negedge; the beat is sampled at the next posedge and is due 4 cycles on.
   task automatic drive(input logic [31:0] xv, yv, wv, input logic mv, input logic push,
                        input logic [31:0] ez, ez2);
      bf.in_nd = 1'b1;
      bf.x     = xv;
      bf.y     = yv;
      bf.w     = wv;
      bf.in_m  = mv;
      if (push) sb_q.push_back('{ez, ez2, mv, cyc + 4});
      @(negedge clk);
      bf.in_nd = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
   endtask

   // Output monitor / scoreboard.
   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb_q.size() != 0 && sb_q[0].due < cyc) begin
         checks++;
         $display("FAIL missing_out_nd: no output by cycle %0d, required one at cycle %0d", cyc, sb_q[0].due);
         void'(sb_q.pop_front());
      end
      if (bf.out_nd === 1'b1) begin
         if (sb_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out_nd: out_nd=1 at cycle %0d, required 0", cyc);
         end else begin
            e = sb_q.pop_front();
            checks++;
            if (cyc !== e.due) $display("FAIL latency: output at cycle %0d, required %0d", cyc, e.due);
            else passes++;
            checks++;
            if (bf.z !== e.z) $display("FAIL z: got %h, required %h (cycle %0d)", bf.z, e.z, cyc);
            else passes++;
            checks++;
            if (bf.z2 !== e.z2) $display("FAIL z2: got %h, required %h (cycle %0d)", bf.z2, e.z2, cyc);
            else passes++;
            checks++;
            if (bf.out_m !== e.m) $display("FAIL out_m: got %b, required %b (cycle %0d)", bf.out_m, e.m, cyc);
            else passes++;
            $display("out cycle=%0d z=%h z2=%h m=%b err=%b", cyc, bf.z, bf.z2, bf.out_m, bf.error);
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1;
      bf.in_nd = 1'b0; bf.x = '0; bf.y = '0; bf.w = '0; bf.in_m = '0;
      repeat (3) @(negedge clk);
      checks++; if (bf.out_nd !== 1'b0) $display("FAIL reset_out_nd: got %b, required 0", bf.out_nd); else passes++;
      checks++; if (bf.z !== 32'h0) $display("FAIL reset_z: got %h, required 0", bf.z); else passes++;
      checks++; if (bf.z2 !== 32'h0) $display("FAIL reset_z2: got %h, required 0", bf.z2); else passes++;
      checks++; if (bf.out_m !== 1'b0) $display("FAIL reset_out_m: got %b, required 0", bf.out_m); else passes++;
      checks++; if (bf.error !== 1'b0) $display("FAIL reset_error: got %b, required 0", bf.error); else passes++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_identity();
      drive(cplx(1000, 2000), cplx(200, -400), cplx(16384, 0), 1'b0, 1'b1,
            cplx(600, 800), cplx(400, 1200));
      drain();
      checks++; if (sb_q.size() != 0) $display("FAIL identity_drain: %0d pending, required 0", sb_q.size()); else passes++;
      checks++; if (bf.error !== 1'b0) $display("FAIL identity_error: got %b, required 0", bf.error); else passes++;
   endtask

   task automatic test_neg_j();
      drive(cplx(0, 0), cplx(100, 0), cplx(0, -16384), 1'b1, 1'b1,
            cplx(0, -50), cplx(0, 50));
      drain();
      checks++; if (sb_q.size() != 0) $display("FAIL neg_j_drain: %0d pending, required 0", sb_q.size()); else passes++;
   endtask

   task automatic test_streaming();
      for (int k = 0; k < 11; k++) begin
         if (k == 8) idle(2);
         drive(cplx(0, 0), cplx(k, 0), cplx(16384, 0), 1'(k % 2), 1'b1,
               cplx(k / 2, 0), cplx(-((k + 1) / 2), 0));
      end
      drain();
      checks++; if (sb_q.size() != 0) $display("FAIL stream_drain: %0d pending, required 0", sb_q.size()); else passes++;
      checks++; if (bf.error !== 1'b0) $display("FAIL stream_error: got %b, required 0", bf.error); else passes++;
   endtask

   task automatic test_saturation();
      drive(cplx(0, 32767), cplx(-32768, 32767), cplx(11585, -11585), 1'b1, 1'b1,
            cplx(-1, 32767), cplx(0, -6786));
      idle(2);
      checks++; if (bf.error !== 1'b0) $display("FAIL sat_error_early: got %b, required 0", bf.error); else passes++;
      idle(1);
      checks++; if (bf.error !== 1'b1) $display("FAIL sat_error_rise: got %b, required 1", bf.error); else passes++;
      idle(10);
      checks++; if (bf.error !== 1'b1) $display("FAIL sat_error_sticky: got %b, required 1", bf.error); else passes++;
      checks++; if (sb_q.size() != 0) $display("FAIL sat_drain: %0d pending, required 0", sb_q.size()); else passes++;
   endtask

   task automatic test_reset_midflight();
      logic [31:0] xv, yv, wv, ez, ez2;
      logic        sat;
      drive(cplx(7000, -7000), cplx(3000, 3000), cplx(16384, 0), 1'b1, 1'b0, '0, '0);
      drive(cplx(-5000, 100), cplx(-3000, 20), cplx(0, 16384), 1'b1, 1'b0, '0, '0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bf.error !== 1'b0) $display("FAIL midflight_error: got %b, required 0", bf.error); else passes++;
      checks++; if (bf.out_nd !== 1'b0) $display("FAIL midflight_quiet: out_nd=%b at cycle %0d, required 0", bf.out_nd, cyc); else passes++;
      @(negedge clk);
      xv = cplx(-300, 500); yv = cplx(1234, -5678); wv = cplx(11585, 11585);
      model(xv, yv, wv, ez, ez2, sat);
      drive(xv, yv, wv, 1'b0, 1'b1, ez, ez2);
      for (int i = 0; i < 3; i++) begin
         checks++; if (bf.out_nd !== 1'b0) $display("FAIL midflight_quiet: out_nd=%b at cycle %0d, required 0", bf.out_nd, cyc); else passes++;
         @(negedge clk);
      end
      drain();
      checks++; if (sb_q.size() != 0) $display("FAIL midflight_drain: %0d pending, required 0", sb_q.size()); else passes++;
   endtask

   task automatic test_simultaneous();
      rst = 1'b1;
      drive(cplx(100, 100), cplx(200, 200), cplx(16384, 0), 1'b1, 1'b0, '0, '0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++; if (bf.out_nd !== 1'b0) $display("FAIL simul_quiet: out_nd=%b at cycle %0d, required 0", bf.out_nd, cyc); else passes++;
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] xv, yv, wv, ez, ez2;
      logic        sat;
      logic        any_sat = 1'b0;
      for (int n = 0; n < 24; n++) begin
         xv = $urandom;
         yv = $urandom;
         wv = cplx(int'($urandom_range(23170)) - 11585, int'($urandom_range(23170)) - 11585);
         model(xv, yv, wv, ez, ez2, sat);
         any_sat = any_sat | sat;
         drive(xv, yv, wv, 1'($urandom_range(1)), 1'b1, ez, ez2);
         if ($urandom_range(3) == 0) idle(1);
      end
      drain();
      checks++; if (sb_q.size() != 0) $display("FAIL b2b_drain: %0d pending, required 0", sb_q.size()); else passes++;
      checks++; if (bf.error !== any_sat) $display("FAIL b2b_error: got %b, required %b", bf.error, any_sat); else passes++;
   endtask

   initial begin
      test_reset();
      test_identity();
      test_neg_j();
      test_streaming();
      test_saturation();
      test_reset_midflight();
      test_simultaneous();
      test_back_to_back();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1);
   end
endmodule
